// File: rtl/up_sample_nn_ctrl_if.sv
// Bundles the start/stall handshake, the read port toward the input stencil
// buffer and the write port toward the nearest-neighbor stencil buffer.
// The controller takes the master side; the surrounding fabric takes the slave side.
interface up_sample_nn_ctrl_if #(
    parameter int CTRL_W = 16
);
    // frame handshake
    logic                   start;
    logic                   stall;
    logic                   busy;
    logic                   done;

    // read side (hw_input_stencil_ub)
    logic                   nn_read_ren;
    logic [2:0][CTRL_W-1:0] nn_read_ctrl_vars;
    logic [CTRL_W-1:0]      nn_read_data;

    // write side (nearest_neighbor_stencil_ub)
    logic                   nn_write_wen;
    logic [2:0][CTRL_W-1:0] nn_write_ctrl_vars;
    logic [CTRL_W-1:0]      nn_write_data;

    modport master (
        input  start,
        input  stall,
        output busy,
        output done,
        output nn_read_ren,
        output nn_read_ctrl_vars,
        input  nn_read_data,
        output nn_write_wen,
        output nn_write_ctrl_vars,
        output nn_write_data
    );

    modport slave (
        output start,
        output stall,
        input  busy,
        input  done,
        input  nn_read_ren,
        input  nn_read_ctrl_vars,
        output nn_read_data,
        input  nn_write_wen,
        input  nn_write_ctrl_vars,
        input  nn_write_data
    );
endinterface

// File: rtl/up_sample_nn_ctrl.sv
// Scheduler for the nearest-neighbor up-sample compute.
// Walks the OUT_H x OUT_W output domain in row-major order, issuing one read
// per unstalled cycle to the input stencil buffer (which applies the >>SHIFT
// itself), then writes the returned pixel to the output stencil buffer one
// cycle later at the same coordinates. One full frame per accepted start.
module up_sample_nn_ctrl #(
    parameter int OUT_W  = 128,
    parameter int OUT_H  = 128,
    parameter int CTRL_W = 16
) (
    input  logic                  clk,
    input  logic                  flush,
    up_sample_nn_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [CTRL_W-1:0] X_LAST = CTRL_W'(OUT_W - 1);
    localparam logic [CTRL_W-1:0] Y_LAST = CTRL_W'(OUT_H - 1);
    localparam logic [CTRL_W-1:0] ONE    = CTRL_W'(1);

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] x_q, x_d;
    logic [CTRL_W-1:0] y_q, y_d;

    // write-side pipeline: one-stage copy of the issued read
    logic              wen_q;
    logic [CTRL_W-1:0] wx_q;
    logic [CTRL_W-1:0] wy_q;

    logic              issue;
    logic              at_x_last;
    logic              at_y_last;

    // a read goes out whenever we are walking the frame and not held back;
    // flush blocks it so nothing new enters the pipe in a flush cycle
    assign issue     = (state_q == RUN) && !bus.stall && !flush;
    assign at_x_last = (x_q == X_LAST);
    assign at_y_last = (y_q == Y_LAST);

    // State register: flush returns the walker to IDLE
    // NOTE: every clocked process uses non-blocking (<=) so all registers
    // update from the same pre-edge values; blocking here would create
    // order-dependent races between always_ff blocks.
    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the frame walker
    // NOTE: state_d gets a default before the case so every path assigns it;
    // a missing default in always_comb would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.stall && at_x_last && at_y_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode: status flags and read request come straight from state
    always_comb begin
        bus.busy              = 1'b0;
        bus.done              = 1'b0;
        bus.nn_read_ren       = 1'b0;
        bus.nn_read_ctrl_vars = {x_q, y_q, {CTRL_W{1'b0}}};
        if (!flush) begin
            bus.busy        = (state_q == RUN) || (state_q == DRAIN);
            bus.done        = (state_q == DONE);
            bus.nn_read_ren = issue;
        end
    end

    // Coordinate counters: x steps every issued read, y steps on x wrap,
    // both return to 0 after the last pixel and stay at 0 outside RUN
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (state_q != RUN) begin
            x_d = '0;
            y_d = '0;
        end else if (issue) begin
            if (at_x_last) begin
                x_d = '0;
                y_d = at_y_last ? '0 : (y_q + ONE);
            end else begin
                x_d = x_q + ONE;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (flush) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Write pipeline: mirror the issued read one cycle later; the captured
    // coordinates hold while no write is pending, and flush drops the
    // in-flight read so it never turns into a write
    always_ff @(posedge clk) begin
        if (flush) begin
            wen_q <= 1'b0;
            wx_q  <= '0;
            wy_q  <= '0;
        end else begin
            wen_q <= issue;
            if (issue) begin
                wx_q <= x_q;
                wy_q <= y_q;
            end
        end
    end

    // Write port: data is the buffer's registered read data passed straight through
    always_comb begin
        bus.nn_write_wen       = wen_q && !flush;
        bus.nn_write_ctrl_vars = {wx_q, wy_q, {CTRL_W{1'b0}}};
        bus.nn_write_data      = bus.nn_read_data;
    end

endmodule

// File: tb/tb_up_sample_nn_ctrl.sv
// Bench for up_sample_nn_ctrl: a 4x2 instance checked every cycle against a
// frame-level reference model under directed and random start/stall/flush,
// and a default 128x128 instance run end to end with both stencil buffers.
module tb_up_sample_nn_ctrl;

    localparam int CW = 16;
    localparam int SW = 4;
    localparam int SH = 2;
    localparam int SN = SW * SH;
    localparam int BW = 128;
    localparam int BH = 128;
    localparam int BN = BW * BH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pc = 0;
    always @(posedge clk) pc <= pc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- small 4x2 instance ----------------
    logic s_flush = 1'b1;
    logic s_start = 1'b0;
    logic s_stall = 1'b0;
    logic [CW-1:0] s_rdata = '0;
    logic [CW-1:0] s_in  [SH/2][SW/2];
    logic [CW-1:0] s_out [SH][SW];

    up_sample_nn_ctrl_if #(.CTRL_W(CW)) s_if ();
    assign s_if.start        = s_start;
    assign s_if.stall        = s_stall;
    assign s_if.nn_read_data = s_rdata;

    up_sample_nn_ctrl #(.OUT_W(SW), .OUT_H(SH), .CTRL_W(CW)) u_small (
        .clk   (clk),
        .flush (s_flush),
        .bus   (s_if)
    );

    // input stencil buffer: registered read of the down-sampled pixel
    always @(posedge clk) begin
        if (s_if.nn_read_ren)
            s_rdata <= s_in[int'(s_if.nn_read_ctrl_vars[1]) >> 1][int'(s_if.nn_read_ctrl_vars[2]) >> 1];
        if (s_if.nn_write_wen)
            s_out[int'(s_if.nn_write_ctrl_vars[1])][int'(s_if.nn_write_ctrl_vars[2])] <= s_if.nn_write_data;
    end

    // frame-level reference: reads remaining, one drain cycle, one done cycle
    bit           m_reading = 0;
    bit           m_drain   = 0;
    bit           m_donep   = 0;
    bit           m_pend    = 0;
    int           m_issued  = 0;
    int           m_py      = 0;
    int           m_px      = 0;
    logic [CW-1:0] m_pdata  = '0;

    always @(posedge clk) begin
        if (s_flush) begin
            m_reading <= 0;
            m_drain   <= 0;
            m_donep   <= 0;
            m_pend    <= 0;
            m_issued  <= 0;
        end else begin
            m_pend <= m_reading && !s_stall;
            if (m_reading && !s_stall) begin
                m_py    <= m_issued / SW;
                m_px    <= m_issued % SW;
                m_pdata <= s_in[(m_issued / SW) >> 1][(m_issued % SW) >> 1];
            end
            if (m_donep) begin
                m_donep <= 0;
            end else if (m_drain) begin
                m_drain <= 0;
                m_donep <= 1;
            end else if (m_reading) begin
                if (!s_stall) begin
                    m_issued <= m_issued + 1;
                    if (m_issued == SN - 1) begin
                        m_reading <= 0;
                        m_drain   <= 1;
                    end
                end
            end else if (s_start) begin
                m_reading <= 1;
                m_issued  <= 0;
            end
        end
    end

    // per-cycle comparison of the small instance against the model
    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            logic e_ren;
            logic e_wen;
            e_ren = !s_flush && m_reading && !s_stall;
            e_wen = !s_flush && m_pend;
            check("busy", s_if.busy, !s_flush && (m_reading || m_drain));
            check("done", s_if.done, !s_flush && m_donep);
            check("ren",  s_if.nn_read_ren, e_ren);
            check("wen",  s_if.nn_write_wen, e_wen);
            if (e_ren)
                check("rd_ctrl", s_if.nn_read_ctrl_vars,
                      {CW'(m_issued % SW), CW'(m_issued / SW), CW'(0)});
            if (e_wen) begin
                check("wr_ctrl", s_if.nn_write_ctrl_vars, {CW'(m_px), CW'(m_py), CW'(0)});
                check("wr_data", s_if.nn_write_data, m_pdata);
            end
        end
    end

    // event log of the small instance, cycles relative to the start edge
    bit          log_en = 0;
    int          p0 = 0;
    int          rd_c[$];
    int          wr_c[$];
    int          dn_c[$];
    logic [31:0] rd_yx[$];
    logic [31:0] wr_yx[$];
    int          s_rd_total = 0;

    always @(negedge clk) begin
        if (s_if.nn_read_ren === 1'b1) s_rd_total <= s_rd_total + 1;
        if (log_en) begin
            if (s_if.nn_read_ren === 1'b1) begin
                rd_c.push_back(pc - p0 + 1);
                rd_yx.push_back({s_if.nn_read_ctrl_vars[1], s_if.nn_read_ctrl_vars[2]});
            end
            if (s_if.nn_write_wen === 1'b1) begin
                wr_c.push_back(pc - p0 + 1);
                wr_yx.push_back({s_if.nn_write_ctrl_vars[1], s_if.nn_write_ctrl_vars[2]});
            end
            if (s_if.done === 1'b1) dn_c.push_back(pc - p0 + 1);
        end
    end

    // Pulse start at cycle 0, then drive stall/restart/flush per relative cycle
    task automatic run_frame(input int st_lo, input int st_hi, input int restart_c, input int flush_c);
        rd_c.delete(); wr_c.delete(); dn_c.delete(); rd_yx.delete(); wr_yx.delete();
        s_start = 1'b1;
        @(posedge clk); #1;
        p0      = pc;
        s_start = 1'b0;
        log_en  = 1;
        for (int c = 1; c <= 18; c++) begin
            s_stall = (c >= st_lo) && (c <= st_hi);
            s_start = (c == restart_c);
            s_flush = (c == flush_c);
            @(posedge clk); #1;
        end
        s_stall = 1'b0; s_start = 1'b0; s_flush = 1'b0;
        log_en  = 0;
    endtask

    // ---------------- default 128x128 instance ----------------
    logic b_flush = 1'b1;
    logic b_start = 1'b0;
    logic [CW-1:0] b_rdata = '0;
    logic [CW-1:0] b_in  [BH/2][BW/2];
    logic [CW-1:0] b_out [BH][BW];
    int b_wn      = 0;
    int b_ord_err = 0;

    up_sample_nn_ctrl_if #(.CTRL_W(CW)) b_if ();
    assign b_if.start        = b_start;
    assign b_if.stall        = 1'b0;
    assign b_if.nn_read_data = b_rdata;

    up_sample_nn_ctrl #(.CTRL_W(CW)) u_big (
        .clk   (clk),
        .flush (b_flush),
        .bus   (b_if)
    );

    always @(posedge clk) begin
        if (b_if.nn_read_ren)
            b_rdata <= b_in[int'(b_if.nn_read_ctrl_vars[1]) >> 1][int'(b_if.nn_read_ctrl_vars[2]) >> 1];
        if (b_if.nn_write_wen)
            b_out[int'(b_if.nn_write_ctrl_vars[1])][int'(b_if.nn_write_ctrl_vars[2])] <= b_if.nn_write_data;
    end

    // row-major order of the big frame's writes
    always @(negedge clk) begin
        if (b_if.nn_write_wen === 1'b1) begin
            if (int'(b_if.nn_write_ctrl_vars[1]) * BW + int'(b_if.nn_write_ctrl_vars[2]) != b_wn)
                b_ord_err <= b_ord_err + 1;
            b_wn <= b_wn + 1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        int bad;
        int got;
        int pb;

        for (int y = 0; y < SH/2; y++)
            for (int x = 0; x < SW/2; x++)
                s_in[y][x] = CW'($urandom);
        for (int y = 0; y < BH/2; y++)
            for (int x = 0; x < BW/2; x++)
                b_in[y][x] = CW'($urandom);

        // reset: flush held three cycles with start asserted
        s_flush = 1'b1; s_start = 1'b1;
        @(posedge clk); #1;
        cmp_en = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_flush = 1'b0;
        @(negedge clk);
        check("rst_rd_ctrl", s_if.nn_read_ctrl_vars, 48'h0);
        check("rst_wr_ctrl", s_if.nn_write_ctrl_vars, 48'h0);
        check("rst_busy", s_if.busy, 1'b0);
        @(posedge clk); #1;
        s_flush = 1'b0; s_start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_run_reads", s_rd_total, 0);

        // unstalled small frame
        run_frame(99, 0, -1, -1);
        check("A_reads",      rd_c.size(), SN);
        check("A_first_rd_c", rd_c[0], 1);
        check("A_last_rd_c",  rd_c[SN-1], 8);
        check("A_writes",     wr_c.size(), SN);
        check("A_first_wr_c", wr_c[0], 2);
        check("A_last_wr_c",  wr_c[SN-1], 9);
        check("A_wr4_yx",     wr_yx[4], {16'd1, 16'd0});
        check("A_dones",      dn_c.size(), 1);
        check("A_done_c",     dn_c[0], 10);
        bad = 0;
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++)
                if (s_out[y][x] !== s_in[y >> 1][x >> 1]) bad++;
        check("A_out_image", bad, 0);

        // stall during cycles 3-4
        run_frame(3, 4, -1, -1);
        check("B_done_c",   dn_c[0], 12);
        check("B_wr_c1",    wr_c[1], 3);
        check("B_wr_yx1",   wr_yx[1], {16'd0, 16'd1});
        check("B_rd_c2",    rd_c[2], 5);
        check("B_rd_yx2",   rd_yx[2], {16'd0, 16'd2});
        check("B_reads",    rd_c.size(), SN);

        // start pulsed again while busy
        run_frame(99, 0, 5, -1);
        check("C_writes", wr_c.size(), SN);
        check("C_dones",  dn_c.size(), 1);
        check("C_done_c", dn_c[0], 10);

        // mid-frame flush at cycle 4
        run_frame(99, 0, -1, 4);
        check("D_dones", dn_c.size(), 0);
        cnt = 0;
        foreach (wr_c[i]) if (wr_c[i] >= 5) cnt++;
        check("D_late_writes", cnt, 0);

        // a fresh frame after the flush starts from (0,0)
        run_frame(99, 0, -1, -1);
        check("E_rd_yx0",  rd_yx[0], 32'h0);
        check("E_writes",  wr_c.size(), SN);
        check("E_done_c",  dn_c[0], 10);

        // random start/stall/flush on the small instance
        for (int i = 0; i < 400; i++) begin
            s_start = ($urandom_range(0, 99) < 20);
            s_stall = ($urandom_range(0, 99) < 30);
            s_flush = ($urandom_range(0, 99) < 3);
            @(posedge clk); #1;
        end
        s_start = 1'b0; s_stall = 1'b0; s_flush = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        // default-size frame end to end
        b_start = 1'b1;
        @(posedge clk); #1;
        pb      = pc;
        b_start = 1'b0;
        got     = -1;
        for (int i = 0; i < 17000; i++) begin
            @(negedge clk);
            if (b_if.done === 1'b1) begin
                got = pc - pb + 1;
                break;
            end
        end
        check("big_done_c", got, BN + 2);
        @(posedge clk); #1;
        @(negedge clk);
        check("big_busy_after", b_if.busy, 1'b0);
        check("big_writes", b_wn, BN);
        check("big_order_errs", b_ord_err, 0);
        bad = 0;
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                if (b_out[y][x] !== b_in[y >> 1][x >> 1]) bad++;
        check("big_out_image", bad, 0);

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
